reaction_timer_ctrl: RTL and testbench

Reaction-timer control stage that produces the 10-bit count value and foul indicator consumed by the four-digit dynamic-scan display block. A start key arms a random-free fixed "get ready" interval. After the interval the block lights a GO indicator and counts elapsed time in 10 ms units until the player key is pressed. A player press during the ready interval is a foul and raises `ErrorFlag`.

---
 rtl/reaction_timer_ctrl_if.sv | 21 ++
 rtl/reaction_timer_ctrl.sv | 130 +++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_ctrl_if.sv
// Key inputs and display-facing status outputs of the reaction timer.
// Keys are plain asynchronous levels and all outputs are registered status; there is no valid/ready handshake on this bundle.
interface reaction_timer_ctrl_if;
    logic       StartKey;
    logic       HitKey;
    logic [9:0] DataOut;
    logic       ErrorFlag;
    logic       GoLed;
    logic       Busy;
    logic [2:0] state_dbg;

    modport master (
        output StartKey, HitKey,
        input  DataOut, ErrorFlag, GoLed, Busy, state_dbg
    );

    modport slave (
        input  StartKey, HitKey,
        output DataOut, ErrorFlag, GoLed, Busy, state_dbg
    );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// Reaction-timer control: key conditioning, tick divider, round FSM and registered
// count/foul outputs for the four-digit display.
module reaction_timer_ctrl #(
    parameter int TICK_DIV    = 500000,
    parameter int READY_TICKS = 200,
    parameter int MAX_COUNT   = 999
) (
    input  logic                  clk_50M,
    input  logic                  rst,
    reaction_timer_ctrl_if.slave  bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int RW = $clog2(READY_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_FOUL  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    // Bit 0 carries StartKey, bit 1 carries HitKey through every conditioning stage.
    logic [1:0]    key_s1_q, key_s1_d;
    logic [1:0]    key_s2_q, key_s2_d;
    logic [1:0]    key_prev_q, key_prev_d;
    logic [1:0]    key_p_q, key_p_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [RW-1:0] ready_cnt_q, ready_cnt_d;
    logic [9:0]    data_q, data_d;
    logic          error_q, error_d;
    logic          go_q, go_d;
    logic          busy_q, busy_d;

    logic start_p, hit_p, tick, timed_q, timed_d, entering, last_ready;

    always_comb begin
        key_s1_d   = {bus.HitKey, bus.StartKey};
        key_s2_d   = key_s1_q;
        key_prev_d = key_s2_q;
        key_p_d    = key_s2_q & ~key_prev_q;
    end

    assign start_p    = key_p_q[0];
    assign hit_p      = key_p_q[1];
    assign timed_q    = (state_q == S_READY) || (state_q == S_RUN);
    assign tick       = timed_q && (tick_cnt_q == TW'(TICK_DIV - 1));
    assign last_ready = tick && (ready_cnt_q == RW'(READY_TICKS - 1));

    // State register
    always_ff @(posedge clk_50M) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a hit always wins over a coincident tick or start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_p) state_d = S_READY;
            S_READY: begin
                if (hit_p)           state_d = S_FOUL;
                else if (last_ready) state_d = S_RUN;
            end
            S_RUN: begin
                if (hit_p)                                       state_d = S_DONE;
                else if (tick && data_q == 10'(MAX_COUNT))       state_d = S_DONE;
            end
            S_DONE:  if (start_p) state_d = S_READY;
            S_FOUL:  if (start_p) state_d = S_READY;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and counter logic, all computed from the upcoming state.
    always_comb begin
        timed_d  = (state_d == S_READY) || (state_d == S_RUN);
        entering = timed_d && (state_d != state_q);

        if (!timed_d || entering || tick) tick_cnt_d = '0;
        else                              tick_cnt_d = tick_cnt_q + TW'(1);

        if (state_d != S_READY || entering) ready_cnt_d = '0;
        else if (tick)                      ready_cnt_d = ready_cnt_q + RW'(1);
        else                                ready_cnt_d = ready_cnt_q;

        data_d = data_q;
        if (state_q == S_RUN && state_d == S_RUN && tick)
            data_d = data_q + 10'd1;
        else if (state_d == S_IDLE || state_d == S_READY || state_d == S_FOUL)
            data_d = '0;

        error_d = (state_d == S_FOUL);
        go_d    = (state_d == S_RUN);
        busy_d  = timed_d;
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            key_s1_q    <= '0;
            key_s2_q    <= '0;
            key_prev_q  <= '0;
            key_p_q     <= '0;
            tick_cnt_q  <= '0;
            ready_cnt_q <= '0;
            data_q      <= '0;
            error_q     <= 1'b0;
            go_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            key_prev_q  <= key_prev_d;
            key_p_q     <= key_p_d;
            tick_cnt_q  <= tick_cnt_d;
            ready_cnt_q <= ready_cnt_d;
            data_q      <= data_d;
            error_q     <= error_d;
            go_q        <= go_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.DataOut   = data_q;
    assign bus.ErrorFlag = error_q;
    assign bus.GoLed     = go_q;
    assign bus.Busy      = busy_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench for reaction_timer_ctrl: directed test-plan steps followed by random
// key activity, every cycle compared against a cycle-count reference model of the round.
module tb_reaction_timer_ctrl;
    localparam int TD = 4;
    localparam int RT = 3;
    localparam int MX = 9;
    localparam int M_IDLE = 0, M_READY = 1, M_RUN = 2, M_DONE = 3, M_FOUL = 4;

    logic clk_50M = 1'b0;
    logic rst     = 1'b1;

    reaction_timer_ctrl_if bus ();

    reaction_timer_ctrl #(
        .TICK_DIV    (TD),
        .READY_TICKS (RT),
        .MAX_COUNT   (MX)
    ) dut (
        .clk_50M (clk_50M),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_50M = ~clk_50M;

    int n_checks = 0;
    int n_fail   = 0;

    bit cur_sk, cur_hk, cur_rst;

    // Reference model: round phase, cycles elapsed in the phase, count and foul flag.
    int       m_mode, m_cyc, m_data;
    bit       m_err;
    bit [3:0] sk_h, hk_h;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A key event is seen at the edge three edges after the first edge that sampled it high.
    task automatic model_edge();
        bit sp, hp;
        if (cur_rst) begin
            m_mode = M_IDLE; m_cyc = 0; m_data = 0; m_err = 0;
            sk_h = '0; hk_h = '0;
            return;
        end
        sp   = sk_h[2] && !sk_h[3];
        hp   = hk_h[2] && !hk_h[3];
        sk_h = {sk_h[2:0], cur_sk};
        hk_h = {hk_h[2:0], cur_hk};
        case (m_mode)
            M_IDLE: if (sp) begin m_mode = M_READY; m_cyc = 0; end
            M_READY: begin
                if (hp) begin
                    m_mode = M_FOUL; m_err = 1;
                end else begin
                    m_cyc++;
                    if (m_cyc == RT * TD) begin m_mode = M_RUN; m_cyc = 0; end
                end
            end
            M_RUN: begin
                if (hp) begin
                    m_mode = M_DONE;
                end else begin
                    m_cyc++;
                    if (m_cyc % TD == 0) begin
                        if (m_data == MX) m_mode = M_DONE;
                        else              m_data++;
                    end
                end
            end
            default: if (sp) begin m_mode = M_READY; m_cyc = 0; m_data = 0; m_err = 0; end
        endcase
    endtask

    task automatic check_outputs();
        check("data_out",   32'(bus.DataOut),   32'(m_data));
        check("error_flag", 32'(bus.ErrorFlag), 32'(m_err));
        check("go_led",     32'(bus.GoLed),     32'(m_mode == M_RUN));
        check("busy",       32'(bus.Busy),      32'(m_mode == M_READY || m_mode == M_RUN));
    endtask

    task automatic step();
        @(negedge clk_50M);
        bus.StartKey = cur_sk;
        bus.HitKey   = cur_hk;
        rst          = cur_rst;
        @(posedge clk_50M);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        cur_sk = 0; cur_hk = 0; cur_rst = 1;
        steps(2);
        cur_rst = 0;
    endtask

    task automatic wait_data(input int v, input int budget, input string tag);
        int k;
        k = 0;
        while (bus.DataOut !== 10'(v) && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(bus.DataOut), 32'(v));
    endtask

    initial begin
        int k;
        bus.StartKey = 1'b0;
        bus.HitKey   = 1'b0;
        cur_sk = 0; cur_hk = 0; cur_rst = 1;

        // Reset state
        do_reset();
        check("reset_data", 32'(bus.DataOut), 32'd0);
        check("reset_busy", 32'(bus.Busy), 32'd0);

        // Normal round: GoLed rises 12 cycles after start_p is sampled
        cur_sk = 1; step(); k = 1;
        steps(2); k = 3;
        cur_sk = 0;
        while (!bus.GoLed && k < 40) begin step(); k++; end
        check("go_rise_edge", 32'(k), 32'd16);
        wait_data(4, 40, "normal_reach4");
        step();
        cur_hk = 1;
        steps(8);
        check("normal_frozen", 32'(bus.DataOut), 32'd5);
        check("normal_done_go", 32'(bus.GoLed), 32'd0);
        check("normal_done_busy", 32'(bus.Busy), 32'd0);
        check("normal_no_err", 32'(bus.ErrorFlag), 32'd0);
        cur_hk = 0;
        steps(3);

        // Foul: hit press seen 6 cycles into READY
        do_reset();
        cur_sk = 1; steps(3);
        cur_sk = 0; steps(3);
        cur_hk = 1; steps(6);
        check("foul_err", 32'(bus.ErrorFlag), 32'd1);
        check("foul_data", 32'(bus.DataOut), 32'd0);
        cur_hk = 0; steps(2);
        cur_sk = 1; steps(4);
        check("foul_restart_err", 32'(bus.ErrorFlag), 32'd0);
        check("foul_restart_busy", 32'(bus.Busy), 32'd1);

        // Timeout: count saturates at MAX_COUNT and the round ends
        cur_sk = 0;
        steps(RT * TD + TD * (MX + 1) + 8);
        check("timeout_data", 32'(bus.DataOut), 32'(MX));
        check("timeout_go", 32'(bus.GoLed), 32'd0);
        check("timeout_busy", 32'(bus.Busy), 32'd0);

        // Hit coincident with the final ready tick is a foul
        do_reset();
        cur_sk = 1; steps(3);
        cur_sk = 0; steps(9);
        cur_hk = 1; steps(4);
        check("coin_ready_err", 32'(bus.ErrorFlag), 32'd1);
        check("coin_ready_go", 32'(bus.GoLed), 32'd0);
        cur_hk = 0; steps(2);

        // Hit coincident with a RUN tick at count 3 stops without incrementing
        cur_sk = 1; steps(3);
        cur_sk = 0;
        wait_data(3, 60, "coin_run_reach3");
        cur_hk = 1;
        steps(6);
        check("coin_run_data", 32'(bus.DataOut), 32'd3);
        check("coin_run_go", 32'(bus.GoLed), 32'd0);
        check("coin_run_err", 32'(bus.ErrorFlag), 32'd0);

        // Held hit key never triggers a foul or a stop
        do_reset();
        cur_hk = 1; steps(3);
        cur_sk = 1; steps(3);
        cur_sk = 0;
        steps(70);
        check("held_data", 32'(bus.DataOut), 32'(MX));
        check("held_err", 32'(bus.ErrorFlag), 32'd0);

        // Reset during RUN discards the round; a later hit does nothing
        cur_hk = 0;
        cur_sk = 1; steps(3);
        cur_sk = 0;
        wait_data(2, 60, "midrun_reach2");
        cur_rst = 1; step();
        check("midrun_rst_data", 32'(bus.DataOut), 32'd0);
        check("midrun_rst_go", 32'(bus.GoLed), 32'd0);
        check("midrun_rst_busy", 32'(bus.Busy), 32'd0);
        step();
        cur_rst = 0;
        cur_hk = 1; steps(8);
        check("post_rst_hit_busy", 32'(bus.Busy), 32'd0);
        check("post_rst_hit_err", 32'(bus.ErrorFlag), 32'd0);
        cur_hk = 0; steps(2);

        // Random key activity with occasional resets
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 9) == 0)  cur_sk = ~cur_sk;
            if ($urandom_range(0, 13) == 0) cur_hk = ~cur_hk;
            cur_rst = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
